// File: rtl/aes_mix_columns_seq_if.sv
// Handshake bundle for the sequential AES MixColumns engine: input state channel,
// result channel and busy status. The slave modport is the engine side.
interface aes_mix_columns_seq_if;
    logic         in_valid_i;
    logic         in_ready_o;
    logic         fwd_ninv_i;
    logic [127:0] state_i;
    logic         out_valid_o;
    logic         out_ready_i;
    logic [127:0] state_o;
    logic         busy_o;

    modport slave (
        input  in_valid_i, fwd_ninv_i, state_i, out_ready_i,
        output in_ready_o, out_valid_o, state_o, busy_o
    );

    modport master (
        output in_valid_i, fwd_ninv_i, state_i, out_ready_i,
        input  in_ready_o, out_valid_o, state_o, busy_o
    );
endinterface

// File: rtl/aes_mix_columns_seq.sv
// Full-state AES MixColumns / InvMixColumns engine; LANES columns per cycle over
// 4/LANES cycles, result held until the consumer accepts it.
module aes_mix_columns_seq #(
    parameter int LANES = 1
) (
    input logic                  clk_i,
    input logic                  rst_i,
    aes_mix_columns_seq_if.slave bus
);
    localparam int BEATS = 4 / LANES;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

    if (LANES != 1 && LANES != 2 && LANES != 4) begin : g_bad_lanes
        $error("aes_mix_columns_seq: LANES must be 1, 2 or 4");
    end

    typedef enum logic [1:0] {IDLE, CALC, HOLD} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic          mode_q;
    logic [127:0]  din_q;
    logic [127:0]  result_q;
    logic [31:0]   lane_out [LANES];
    logic          in_ready;
    logic          load;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (8'h1b & {8{a[7]}});
    endfunction

    // Coefficients never exceed 0x0e, so four shift-and-add steps suffice.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] c);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 4; i++) begin
            if (c[i]) p ^= x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Row i uses coefficient k[(j - i) mod 4] for input row j (circulant, rotated right by i).
    function automatic logic [31:0] mix_col(input logic [31:0] col, input logic fwd);
        logic [3:0]  k [4];
        logic [7:0]  a [4];
        logic [7:0]  r;
        logic [1:0]  idx;
        logic [31:0] res;
        if (fwd) k = '{4'h2, 4'h3, 4'h1, 4'h1};
        else     k = '{4'he, 4'hb, 4'hd, 4'h9};
        for (int j = 0; j < 4; j++) a[j] = col[31-8*j -: 8];
        res = '0;
        for (int i = 0; i < 4; i++) begin
            r = 8'h00;
            for (int j = 0; j < 4; j++) begin
                idx = 2'(j - i);
                r ^= gmul(a[j], k[idx]);
            end
            res[31-8*i -: 8] = r;
        end
        return res;
    endfunction

    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            lane_out[l] = mix_col(din_q[127-32*(int'(cnt_q)*LANES+l) -: 32], mode_q);
        end
    end

    // The ready path from out_ready_i is combinational so HOLD can hand off straight into CALC.
    assign in_ready = (state_q == IDLE) | ((state_q == HOLD) & bus.out_ready_i);
    assign load     = bus.in_valid_i & in_ready;

    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch is inferred.
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (load) state_d = CALC;
            CALC:    if (cnt_q == LAST) state_d = HOLD;
            HOLD: begin
                if (load)                 state_d = CALC;
                else if (bus.out_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        // NOTE: non-blocking assignments only; the data registers are reset too so state_o reads 0 after reset.
        if (!rst_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            mode_q   <= 1'b0;
            din_q    <= '0;
            result_q <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                din_q  <= bus.state_i;
                mode_q <= bus.fwd_ninv_i;
                cnt_q  <= '0;
            end else if (state_q == CALC) begin
                for (int l = 0; l < LANES; l++) begin
                    result_q[127-32*(int'(cnt_q)*LANES+l) -: 32] <= lane_out[l];
                end
                cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
            end
        end
    end

    assign bus.in_ready_o  = in_ready;
    assign bus.out_valid_o = (state_q == HOLD);
    assign bus.busy_o      = (state_q != IDLE);
    assign bus.state_o     = result_q;
endmodule

// File: tb/tb_aes_mix_columns_seq.sv
// Directed bench for aes_mix_columns_seq: one instance each of LANES=1,2,4 driven
// through per-lane stimulus arrays, with hand-computed FIPS-197 vectors.
module tb_aes_mix_columns_seq;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    aes_mix_columns_seq_if b1 ();
    aes_mix_columns_seq_if b2 ();
    aes_mix_columns_seq_if b4 ();

    aes_mix_columns_seq #(.LANES(1)) u_l1 (.clk_i(clk), .rst_i(rst), .bus(b1.slave));
    aes_mix_columns_seq #(.LANES(2)) u_l2 (.clk_i(clk), .rst_i(rst), .bus(b2.slave));
    aes_mix_columns_seq #(.LANES(4)) u_l4 (.clk_i(clk), .rst_i(rst), .bus(b4.slave));

    // Index 0 -> LANES=1, 1 -> LANES=2, 2 -> LANES=4
    logic         in_valid  [3];
    logic         fwd_in    [3];
    logic [127:0] state_in  [3];
    logic         out_ready [3];
    logic         in_ready  [3];
    logic         out_valid [3];
    logic         busy      [3];
    logic [127:0] state_out [3];
    int           beats     [3] = '{4, 2, 1};

    assign b1.in_valid_i = in_valid[0];  assign b2.in_valid_i = in_valid[1];  assign b4.in_valid_i = in_valid[2];
    assign b1.fwd_ninv_i = fwd_in[0];    assign b2.fwd_ninv_i = fwd_in[1];    assign b4.fwd_ninv_i = fwd_in[2];
    assign b1.state_i    = state_in[0];  assign b2.state_i    = state_in[1];  assign b4.state_i    = state_in[2];
    assign b1.out_ready_i = out_ready[0]; assign b2.out_ready_i = out_ready[1]; assign b4.out_ready_i = out_ready[2];
    assign in_ready[0]  = b1.in_ready_o;  assign in_ready[1]  = b2.in_ready_o;  assign in_ready[2]  = b4.in_ready_o;
    assign out_valid[0] = b1.out_valid_o; assign out_valid[1] = b2.out_valid_o; assign out_valid[2] = b4.out_valid_o;
    assign busy[0]      = b1.busy_o;      assign busy[1]      = b2.busy_o;      assign busy[2]      = b4.busy_o;
    assign state_out[0] = b1.state_o;     assign state_out[1] = b2.state_o;     assign state_out[2] = b4.state_o;

    localparam logic [127:0] FIPS_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] FIPS_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [127:0] D4_IN    = 128'hd4d4d4d5_d4d4d4d5_d4d4d4d5_d4d4d4d5;
    localparam logic [127:0] D4_OUT   = 128'hd5d5d7d6_d5d5d7d6_d5d5d7d6_d5d5d7d6;

    int checks = 0;
    int errors = 0;

    // Full transaction on one lane set: handshake, latency, result, drain.
    task automatic xfer(input int s, input logic [127:0] din, input logic fwd,
                        input logic [127:0] exp, input string name);
        int w;
        int lat;
        @(negedge clk);
        state_in[s] = din; fwd_in[s] = fwd; in_valid[s] = 1'b1; out_ready[s] = 1'b0;
        w = 0;
        while (!in_ready[s] && w < 20) begin @(negedge clk); w++; end
        checks++;
        if (in_ready[s] !== 1'b1) begin errors++; $display("FAIL %s in_ready: got %b expected 1", name, in_ready[s]); end
        @(posedge clk);
        @(negedge clk);
        in_valid[s] = 1'b0;
        lat = 0;
        while (out_valid[s] !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
        checks++;
        if (lat !== beats[s]) begin errors++; $display("FAIL %s latency: got %0d expected %0d", name, lat, beats[s]); end
        checks++;
        if (state_out[s] !== exp) begin errors++; $display("FAIL %s state_o: got %h expected %h", name, state_out[s], exp); end
        out_ready[s] = 1'b1;
        @(negedge clk);
        out_ready[s] = 1'b0;
        checks++;
        if (out_valid[s] !== 1'b0 || busy[s] !== 1'b0) begin
            errors++; $display("FAIL %s drain: got valid=%b busy=%b expected 0 0", name, out_valid[s], busy[s]);
        end
    endtask

    task automatic test_reset();
        for (int s = 0; s < 3; s++) begin
            in_valid[s] = 1'b0; fwd_in[s] = 1'b1; state_in[s] = '0; out_ready[s] = 1'b0;
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            checks++;
            if (out_valid[s] !== 1'b0 || busy[s] !== 1'b0 || in_ready[s] !== 1'b1 || state_out[s] !== '0) begin
                errors++;
                $display("FAIL reset[%0d]: got valid=%b busy=%b ready=%b state=%h expected 0 0 1 0",
                         s, out_valid[s], busy[s], in_ready[s], state_out[s]);
            end
        end
        rst = 1'b1;
    endtask

    task automatic test_forward();
        xfer(0, FIPS_IN, 1'b1, FIPS_OUT, "fwd_l1");
        xfer(1, FIPS_IN, 1'b1, FIPS_OUT, "fwd_l2");
        xfer(2, FIPS_IN, 1'b1, FIPS_OUT, "fwd_l4");
    endtask

    task automatic test_inverse();
        xfer(0, FIPS_OUT, 1'b0, FIPS_IN, "inv_l1");
        xfer(1, D4_IN,    1'b1, D4_OUT, "d4_fwd_l2");
        xfer(1, D4_OUT,   1'b0, D4_IN,  "d4_inv_l2");
        xfer(2, FIPS_OUT, 1'b0, FIPS_IN, "inv_l4");
    endtask

    task automatic test_backpressure();
        int w;
        @(negedge clk);
        state_in[0] = D4_IN; fwd_in[0] = 1'b1; in_valid[0] = 1'b1; out_ready[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        state_in[0] = FIPS_IN;
        w = 0;
        while (out_valid[0] !== 1'b1 && w < 20) begin @(negedge clk); w++; end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (out_valid[0] !== 1'b1 || in_ready[0] !== 1'b0 || state_out[0] !== D4_OUT) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got valid=%b ready=%b state=%h expected 1 0 %h",
                         i, out_valid[0], in_ready[0], state_out[0], D4_OUT);
            end
            @(negedge clk);
        end
        in_valid[0] = 1'b0;
        out_ready[0] = 1'b1;
        @(negedge clk);
        out_ready[0] = 1'b0;
        checks++;
        if (out_valid[0] !== 1'b0 || busy[0] !== 1'b0 || in_ready[0] !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: got valid=%b busy=%b ready=%b expected 0 0 1", out_valid[0], busy[0], in_ready[0]);
        end
        repeat (6) @(negedge clk);
        checks++;
        if (out_valid[0] !== 1'b0 || busy[0] !== 1'b0) begin
            errors++; $display("FAIL bp_no_capture: got valid=%b busy=%b expected 0 0", out_valid[0], busy[0]);
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] din [3] = '{FIPS_IN, D4_IN, FIPS_OUT};
        logic         fwd [3] = '{1'b1, 1'b1, 1'b0};
        logic [127:0] exp [3] = '{FIPS_OUT, D4_OUT, FIPS_IN};
        int  in_idx;
        int  n_out;
        int  last_out;
        int  cyc;
        logic in_hs;
        in_idx = 0; n_out = 0; last_out = 0; cyc = 0;
        @(negedge clk);
        out_ready[0] = 1'b1; in_valid[0] = 1'b1; state_in[0] = din[0]; fwd_in[0] = fwd[0];
        while (n_out < 3 && cyc < 60) begin
            in_hs = in_valid[0] & in_ready[0];
            if (out_valid[0] === 1'b1) begin
                checks++;
                if (state_out[0] !== exp[n_out]) begin
                    errors++; $display("FAIL b2b_data[%0d]: got %h expected %h", n_out, state_out[0], exp[n_out]);
                end
                if (n_out > 0) begin
                    checks++;
                    if (cyc - last_out !== beats[0] + 1) begin
                        errors++; $display("FAIL b2b_gap[%0d]: got %0d expected %0d", n_out, cyc - last_out, beats[0] + 1);
                    end
                end
                last_out = cyc;
                n_out++;
            end
            @(posedge clk);
            @(negedge clk);
            cyc++;
            if (in_hs) begin
                in_idx++;
                if (in_idx < 3) begin state_in[0] = din[in_idx]; fwd_in[0] = fwd[in_idx]; end
                else in_valid[0] = 1'b0;
            end
        end
        checks++;
        if (n_out !== 3) begin errors++; $display("FAIL b2b_count: got %0d expected 3", n_out); end
        repeat (6) @(negedge clk);
        checks++;
        if (out_valid[0] !== 1'b0 || busy[0] !== 1'b0) begin
            errors++; $display("FAIL b2b_extra: got valid=%b busy=%b expected 0 0", out_valid[0], busy[0]);
        end
        out_ready[0] = 1'b0;
    endtask

    task automatic test_mode_change();
        int w;
        @(negedge clk);
        state_in[0] = D4_IN; fwd_in[0] = 1'b1; in_valid[0] = 1'b1; out_ready[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid[0] = 1'b0; state_in[0] = FIPS_OUT; fwd_in[0] = 1'b0;
        @(negedge clk);
        state_in[0] = 128'h01234567_89abcdef_fedcba98_76543210; fwd_in[0] = 1'b1;
        @(negedge clk);
        fwd_in[0] = 1'b0;
        w = 0;
        while (out_valid[0] !== 1'b1 && w < 20) begin @(negedge clk); w++; end
        checks++;
        if (state_out[0] !== D4_OUT) begin errors++; $display("FAIL mode_change: got %h expected %h", state_out[0], D4_OUT); end
        out_ready[0] = 1'b1;
        @(negedge clk);
        out_ready[0] = 1'b0;
    endtask

    task automatic test_reset_mid_calc();
        @(negedge clk);
        state_in[0] = FIPS_IN; fwd_in[0] = 1'b1; in_valid[0] = 1'b1; out_ready[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid[0] = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy[0] !== 1'b1 || out_valid[0] !== 1'b0) begin
            errors++; $display("FAIL rst_pre: got busy=%b valid=%b expected 1 0", busy[0], out_valid[0]);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid[0] !== 1'b0 || busy[0] !== 1'b0 || state_out[0] !== '0 || in_ready[0] !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid: got valid=%b busy=%b state=%h ready=%b expected 0 0 0 1",
                     out_valid[0], busy[0], state_out[0], in_ready[0]);
        end
        rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid[0] !== 1'b0) begin errors++; $display("FAIL rst_spurious[%0d]: got valid=1 expected 0", i); end
        end
        xfer(0, D4_IN, 1'b1, D4_OUT, "post_rst_l1");
    endtask

    initial begin
        test_reset();
        test_forward();
        test_inverse();
        test_backpressure();
        test_back_to_back();
        test_mode_change();
        test_reset_mid_calc();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
